serdiv_arbiter: RTL and testbench

- Shares one serdiv serial divider among NREQ requesters, such as a core's integer divide path and a second issue slot or a co-processor.
- Arbitration is round-robin. Only one operation is in flight at a time.
- Operands and the owning requester are registered. The request is issued to serdiv, the result is captured, and it is routed back to the owner on a valid/ready response channel.
- Sits between the requesters and a single serdiv instance. flush_i is forwarded to the divider.

---
 rtl/serdiv_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_serdiv_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdiv_arbiter.sv
// ============================================================================
// Module   : serdiv_arbiter
// Brief    : Round-robin arbiter sharing one serdiv divider among NREQ
//            requesters; optional watchdog under SERDIV_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdiv_arbiter #(
  parameter int NREQ          = 2,
  parameter int WIDTH         = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int TIMEOUT_CYC   = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [NREQ-1:0]               req_vld_i,
  output logic [NREQ-1:0]               req_rdy_o,
  input  logic [NREQ*WIDTH-1:0]         req_op_a_i,
  input  logic [NREQ*WIDTH-1:0]         req_op_b_i,
  input  logic [NREQ*2-1:0]             req_opcode_i,
  input  logic [NREQ*TRANS_ID_BITS-1:0] req_id_i,
  output logic [NREQ-1:0]               rsp_vld_o,
  input  logic [NREQ-1:0]               rsp_rdy_i,
  output logic [WIDTH-1:0]              rsp_res_o,
  output logic [TRANS_ID_BITS-1:0]      rsp_id_o,
  output logic                          rsp_err_o,
  output logic                          div_in_vld_o,
  input  logic                          div_in_rdy_i,
  output logic [WIDTH-1:0]              div_op_a_o,
  output logic [WIDTH-1:0]              div_op_b_o,
  output logic [1:0]                    div_opcode_o,
  output logic [TRANS_ID_BITS-1:0]      div_id_o,
  output logic                          div_flush_o,
  input  logic                          div_out_vld_i,
  output logic                          div_out_rdy_o,
  input  logic [WIDTH-1:0]              div_res_i,
  input  logic [TRANS_ID_BITS-1:0]      div_id_i
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_W-1:0]           r_rr_ptr;
  logic [PTR_W-1:0]           r_owner;
  logic [WIDTH-1:0]           r_op_a;
  logic [WIDTH-1:0]           r_op_b;
  logic [1:0]                 r_opcode;
  logic [TRANS_ID_BITS-1:0]   r_id;
  logic [WIDTH-1:0]           r_res;
  logic [TRANS_ID_BITS-1:0]   r_res_id;
  logic                       r_err;

  logic                       w_gnt_vld;
  logic [PTR_W-1:0]           w_gnt_idx;
  logic [PTR_W-1:0]           w_rr_nxt;
  logic                       w_accept;
  logic                       w_div_done;
  logic                       w_rsp_hs;
  logic                       w_timeout;

  // Grant search starts at rr_ptr and wraps at NREQ-1 back to 0.
  always_comb begin
    int               v_j;
    logic [PTR_W-1:0] v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    v_j       = 0;
    v_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_j = int'(r_rr_ptr) + i;
      if (v_j >= NREQ) begin
        v_j = v_j - NREQ;
      end
      v_idx = PTR_W'(v_j);
      if (!w_gnt_vld && req_vld_i[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = v_idx;
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_gnt_vld && !flush_i;
  assign w_div_done = (r_state == S_WAIT) && div_out_vld_i;
  assign w_rsp_hs   = (r_state == S_RESP) && rsp_rdy_i[r_owner] && !flush_i;
  assign w_rr_nxt   = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + PTR_W'(1);

`ifdef SERDIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  // Fires on the TIMEOUT_CYC-th cycle spent in ISSUE/WAIT.
  assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !w_div_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout && !flush_i) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_err     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_state_nxt = S_RESP;
        end else if (div_in_rdy_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_out_vld_i || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_opcode <= '0;
      r_id     <= '0;
      r_res    <= '0;
      r_res_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner  <= w_gnt_idx;
        r_op_a   <= req_op_a_i[w_gnt_idx*WIDTH +: WIDTH];
        r_op_b   <= req_op_b_i[w_gnt_idx*WIDTH +: WIDTH];
        r_opcode <= req_opcode_i[w_gnt_idx*2 +: 2];
        r_id     <= req_id_i[w_gnt_idx*TRANS_ID_BITS +: TRANS_ID_BITS];
      end
      if (w_div_done) begin
        r_res    <= div_res_i;
        r_res_id <= div_id_i;
      end else if (w_timeout) begin
        r_res    <= '1;
        r_res_id <= r_id;
      end
      if (w_rsp_hs) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  // A flush cancels any handshake in the same cycle on both sides.
  assign req_rdy_o     = (w_accept && !rst) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign rsp_vld_o     = ((r_state == S_RESP) && !flush_i) ? (NREQ'(1) << r_owner) : '0;
  assign rsp_res_o     = r_res;
  assign rsp_id_o      = r_res_id;
  assign rsp_err_o     = (rsp_vld_o != '0) && r_err;

  assign div_in_vld_o  = (r_state == S_ISSUE) && !flush_i;
  assign div_op_a_o    = r_op_a;
  assign div_op_b_o    = r_op_b;
  assign div_opcode_o  = r_opcode;
  assign div_id_o      = r_id;
  assign div_out_rdy_o = (r_state == S_WAIT);
  assign div_flush_o   = flush_i | w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_serdiv_arbiter.sv
// ============================================================================
// Module   : tb_serdiv_arbiter
// Brief    : Directed, table-driven bench for serdiv_arbiter with a
//            behavioural serdiv stub.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serdiv_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 64;
  localparam int TIB  = 3;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic                clk;
  logic                rst;
  logic                flush_i;
  logic [NREQ-1:0]     req_vld_i;
  logic [NREQ-1:0]     req_rdy_o;
  logic [NREQ*W-1:0]   req_op_a_i;
  logic [NREQ*W-1:0]   req_op_b_i;
  logic [NREQ*2-1:0]   req_opcode_i;
  logic [NREQ*TIB-1:0] req_id_i;
  logic [NREQ-1:0]     rsp_vld_o;
  logic [NREQ-1:0]     rsp_rdy_i;
  logic [W-1:0]        rsp_res_o;
  logic [TIB-1:0]      rsp_id_o;
  logic                rsp_err_o;
  logic                div_in_vld_o;
  logic                div_in_rdy_i;
  logic [W-1:0]        div_op_a_o;
  logic [W-1:0]        div_op_b_o;
  logic [1:0]          div_opcode_o;
  logic [TIB-1:0]      div_id_o;
  logic                div_flush_o;
  logic                div_out_vld_i;
  logic                div_out_rdy_o;
  logic [W-1:0]        div_res_i;
  logic [TIB-1:0]      div_id_i;

  int n_chk  = 0;
  int n_fail = 0;

  serdiv_arbiter #(
    .NREQ(NREQ), .WIDTH(W), .TRANS_ID_BITS(TIB), .TIMEOUT_CYC(128)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .req_opcode_i(req_opcode_i), .req_id_i(req_id_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i),
    .rsp_res_o(rsp_res_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .div_in_vld_o(div_in_vld_o), .div_in_rdy_i(div_in_rdy_i),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_opcode_o(div_opcode_o), .div_id_o(div_id_o),
    .div_flush_o(div_flush_o), .div_out_vld_i(div_out_vld_i),
    .div_out_rdy_o(div_out_rdy_o), .div_res_i(div_res_i), .div_id_i(div_id_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V divide semantics, including divide-by-zero and signed overflow.
  function automatic logic [63:0] dm(input logic [63:0] a, input logic [63:0] b,
                                     input logic [1:0] op);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    case (op)
      2'b00:   dm = (b == 64'd0) ? '1 : a / b;
      2'b01:   dm = (b == 64'd0) ? '1 : ((a == MINV && b == '1) ? a : 64'(sa / sb));
      2'b10:   dm = (b == 64'd0) ? a : a % b;
      default: dm = (b == 64'd0) ? a : ((a == MINV && b == '1) ? 64'd0 : 64'(sa % sb));
    endcase
  endfunction

  // serdiv stub: fixed 4-cycle latency, single operation in flight.
  logic        s_busy;
  int          s_cnt;
  logic [63:0] s_a, s_b;
  logic [1:0]  s_op;
  logic [2:0]  s_id;

  assign div_in_rdy_i = !s_busy && !div_out_vld_i;

  always @(posedge clk) begin
    if (rst || div_flush_o) begin
      s_busy        <= 1'b0;
      s_cnt         <= 0;
      div_out_vld_i <= 1'b0;
    end else if (!s_busy && !div_out_vld_i) begin
      if (div_in_vld_o) begin
        s_busy <= 1'b1;
        s_cnt  <= 3;
        s_a    <= div_op_a_o;
        s_b    <= div_op_b_o;
        s_op   <= div_opcode_o;
        s_id   <= div_id_o;
      end
    end else if (s_busy) begin
      if (s_cnt == 0) begin
        s_busy        <= 1'b0;
        div_out_vld_i <= 1'b1;
        div_res_i     <= dm(s_a, s_b, s_op);
        div_id_i      <= s_id;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end else if (div_out_rdy_o) begin
      div_out_vld_i <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [63:0] a0, b0;
    logic [1:0]  op0;
    logic [2:0]  id0;
    logic [63:0] a1, b1;
    logic [1:0]  op1;
    logic [2:0]  id1;
    logic [1:0]  gnt;
    logic [63:0] res;
    logic [2:0]  id;
  } vec_t;

  vec_t vt [8];

  task automatic drive(input vec_t v);
    req_op_a_i   = {v.a1, v.a0};
    req_op_b_i   = {v.b1, v.b0};
    req_opcode_i = {v.op1, v.op0};
    req_id_i     = {v.id1, v.id0};
    req_vld_i    = v.mask;
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (rsp_vld_o == '0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int          k;
    logic [63:0] ea;
    drive(v);
    rsp_rdy_i = '0;
    #1;
    k = 0;
    while (req_rdy_o == '0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, " gnt"}, 64'(req_rdy_o), 64'(v.gnt));
    ea = v.gnt[1] ? v.a1 : v.a0;
    @(posedge clk); #1;
    req_vld_i = '0;
    chk({nm, " issue vld"}, 64'(div_in_vld_o), 64'd1);
    chk({nm, " issue op_a"}, div_op_a_o, ea);
    wait_rsp();
    chk({nm, " rsp_vld"}, 64'(rsp_vld_o), 64'(v.gnt));
    chk({nm, " rsp_res"}, rsp_res_o, v.res);
    chk({nm, " rsp_id"}, 64'(rsp_id_o), 64'(v.id));
    chk({nm, " rsp_err"}, 64'(rsp_err_o), 64'd0);
    rsp_rdy_i = 2'b11;
    @(posedge clk); #1;
    rsp_rdy_i = '0;
    chk({nm, " idle after rsp"}, 64'(rsp_vld_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   seen;

    rst = 1'b1; flush_i = 1'b0; req_vld_i = '0; rsp_rdy_i = '0;
    req_op_a_i = '0; req_op_b_i = '0; req_opcode_i = '0; req_id_i = '0;

    vt[0] = '{2'b01, 64'd100, 64'd7, 2'b00, 3'd1, 64'd0, 64'd1, 2'b00, 3'd0,
              2'b01, 64'd14, 3'd1};
    vt[1] = '{2'b11, 64'd100, 64'd7, 2'b00, 3'd3, 64'd100, 64'd7, 2'b10, 3'd2,
              2'b10, 64'd2, 3'd2};
    vt[2] = '{2'b11, 64'd100, 64'd7, 2'b00, 3'd3, 64'd100, 64'd7, 2'b10, 3'd2,
              2'b01, 64'd14, 3'd3};
    vt[3] = '{2'b10, 64'd0, 64'd1, 2'b00, 3'd0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 2'b01, 3'd4,
              2'b10, 64'hFFFF_FFFF_FFFF_FFFA, 3'd4};
    vt[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 2'b11, 3'd5, 64'd0, 64'd1, 2'b00, 3'd0,
              2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 3'd5};
    vt[5] = '{2'b10, 64'd0, 64'd1, 2'b00, 3'd0, 64'd12345, 64'd0, 2'b00, 3'd6,
              2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6};
    vt[6] = '{2'b10, 64'd0, 64'd1, 2'b00, 3'd0, 64'd55, 64'd0, 2'b10, 3'd7,
              2'b10, 64'd55, 3'd7};
    vt[7] = '{2'b11, 64'd1000, 64'd10, 2'b00, 3'd0, 64'd5, 64'd5, 2'b00, 3'd1,
              2'b01, 64'd100, 3'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", 64'({req_rdy_o, rsp_vld_o, div_in_vld_o, div_out_rdy_o,
                              div_flush_o, rsp_err_o}), 64'd0);
    chk("reset res", rsp_res_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle no req", 64'({req_rdy_o, div_in_vld_o}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i], $sformatf("vec%0d", i));
    end

    // Backpressure on requester 0 while requester 1 waits (rr_ptr = 1).
    v = '{2'b01, 64'd200, 64'd9, 2'b00, 3'd4, 64'd50, 64'd5, 2'b00, 3'd5,
          2'b01, 64'd22, 3'd4};
    drive(v);
    #1;
    chk("bp gnt", 64'(req_rdy_o), 64'd1);
    @(posedge clk); #1;
    req_vld_i = '0;
    wait_rsp();
    chk("bp rsp_res", rsp_res_o, 64'd22);
    req_vld_i = 2'b10;
    rsp_rdy_i = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp hold vld", 64'(rsp_vld_o), 64'd1);
      chk("bp hold res", rsp_res_o, 64'd22);
      chk("bp hold id", 64'(rsp_id_o), 64'd4);
      chk("bp hold rdy", 64'(req_rdy_o), 64'd0);
    end
    rsp_rdy_i = 2'b01;
    #1;
    chk("bp hs cycle rdy", 64'(req_rdy_o), 64'd0);
    @(posedge clk); #1;
    rsp_rdy_i = '0;
    chk("bp after hs vld", 64'(rsp_vld_o), 64'd0);
    chk("bp next grant", 64'(req_rdy_o), 64'd2);
    @(posedge clk); #1;
    req_vld_i = '0;
    wait_rsp();
    chk("bp req1 vld", 64'(rsp_vld_o), 64'd2);
    chk("bp req1 res", rsp_res_o, 64'd10);
    chk("bp req1 id", 64'(rsp_id_o), 64'd5);
    rsp_rdy_i = 2'b10;
    @(posedge clk); #1;
    rsp_rdy_i = '0;

    // Flush: blocks a grant in IDLE, then aborts an operation in WAIT (rr_ptr = 0).
    v = '{2'b01, 64'd1000, 64'd3, 2'b00, 3'd6, 64'd0, 64'd1, 2'b00, 3'd0,
          2'b01, 64'd333, 3'd6};
    drive(v);
    flush_i = 1'b1;
    #1;
    chk("flush idle rdy", 64'(req_rdy_o), 64'd0);
    chk("flush idle div_flush", 64'(div_flush_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("post flush grant", 64'(req_rdy_o), 64'd1);
    @(posedge clk); #1;
    req_vld_i = '0;
    chk("flush issue vld", 64'(div_in_vld_o), 64'd1);
    @(posedge clk); #1;
    chk("flush in wait", 64'(div_out_rdy_o), 64'd1);
    flush_i = 1'b1;
    #1;
    chk("flush wait div_flush", 64'(div_flush_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush to idle", 64'({rsp_vld_o, div_in_vld_o, div_out_rdy_o}), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_vld_o != '0) seen++;
    end
    chk("flush no rsp", 64'(seen), 64'd0);
    v = '{2'b11, 64'd1000, 64'd3, 2'b00, 3'd1, 64'd7, 64'd2, 2'b00, 3'd2,
          2'b01, 64'd333, 3'd1};
    run_txn(v, "post flush");

    // Reset while a response is pending (rr_ptr = 1 beforehand).
    v = '{2'b01, 64'd81, 64'd9, 2'b00, 3'd7, 64'd0, 64'd1, 2'b00, 3'd0,
          2'b01, 64'd9, 3'd7};
    drive(v);
    #1;
    chk("rst seq gnt", 64'(req_rdy_o), 64'd1);
    @(posedge clk); #1;
    req_vld_i = '0;
    wait_rsp();
    chk("rst seq rsp_vld", 64'(rsp_vld_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset outputs", 64'({req_rdy_o, rsp_vld_o, div_in_vld_o, div_out_rdy_o,
                                  div_flush_o, rsp_err_o}), 64'd0);
    rst = 1'b0;
    chk("mid reset res", rsp_res_o, 64'd0);
    v = '{2'b11, 64'd9, 64'd2, 2'b10, 3'd2, 64'd8, 64'd2, 2'b00, 3'd3,
          2'b01, 64'd1, 3'd2};
    run_txn(v, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
